loop_div_ctrl: RTL

//  Sequencer for the programmable loop divider: accepts new divide ratios over
//  a valid/ready handshake and applies them glitch-free. It waits for an output

---
 rtl/loop_div_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/loop_div_ctrl.sv
// Loop divider update sequencer: accepts a new ratio over valid/ready, waits
// for the end of an output period, holds the divider in reset while the ratio
// is loaded, releases it and waits for the output to settle before signalling done.
module loop_div_ctrl #(
    parameter int DIV_W   = 6,
    parameter int DEF_DIV = 8,
    parameter int HOLD    = 3,
    parameter int SETTLE  = 2,
    parameter int TMO     = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [DIV_W-1:0] req_div_n,
    output logic             req_ready,
    input  logic             clko_fb,
    output logic [DIV_W-1:0] div_n,
    output logic             div_rstn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_EDGE, S_HOLD, S_SETTLE} state_t;

    localparam logic [3:0]       HOLD_LAST   = 4'(HOLD - 1);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]       TMO_LAST    = 8'(TMO - 1);
    localparam logic [DIV_W-1:0] DEF_N       = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_N       = DIV_W'(2);

    state_t           state, state_nx;
    logic [3:0]       hcnt, hcnt_nx, hcnt_inc;
    logic [3:0]       scnt, scnt_nx, scnt_inc;
    logic [7:0]       tcnt, tcnt_nx, tcnt_inc;
    logic [DIV_W-1:0] pending, pending_nx, div_n_nx;
    logic             div_rstn_nx, done_nx, err_nx, timeout_nx;
    logic             fb_q, rise, fall, xfer, tmo_hit;

    // clko_fb is derived from clk, so a single register gives clean edge detect
    assign rise     = clko_fb & ~fb_q;
    assign fall     = ~clko_fb & fb_q;
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign xfer      = req_valid & req_ready;
    assign tmo_hit   = (tcnt == TMO_LAST);

    // Saturating counters: they cannot wrap before the state exits
    assign hcnt_inc = (hcnt == 4'hF) ? hcnt : hcnt + 4'd1;
    assign scnt_inc = (scnt == 4'hF) ? scnt : scnt + 4'd1;
    assign tcnt_inc = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

    // Next-state and next-output decode; pulses default low every cycle
    always_comb begin
        state_nx    = state;
        hcnt_nx     = hcnt;
        scnt_nx     = scnt;
        tcnt_nx     = tcnt;
        pending_nx  = pending;
        div_n_nx    = div_n;
        div_rstn_nx = div_rstn;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        timeout_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    if (req_div_n >= MIN_N) begin
                        pending_nx = req_div_n;
                        tcnt_nx    = 8'd0;
                        state_nx   = S_WAIT_EDGE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_WAIT_EDGE: begin
                tcnt_nx = tcnt_inc;
                // a falling edge marks the end of an output period
                if (fall || tmo_hit) begin
                    timeout_nx  = ~fall;
                    div_rstn_nx = 1'b0;
                    hcnt_nx     = 4'd0;
                    state_nx    = S_HOLD;
                end
            end
            S_HOLD: begin
                div_rstn_nx = 1'b0;
                div_n_nx    = pending;
                if (hcnt == HOLD_LAST) begin
                    div_rstn_nx = 1'b1;
                    scnt_nx     = 4'd0;
                    tcnt_nx     = 8'd0;
                    state_nx    = S_SETTLE;
                end else begin
                    hcnt_nx = hcnt_inc;
                end
            end
            S_SETTLE: begin
                tcnt_nx = tcnt_inc;
                if (rise) scnt_nx = scnt_inc;
                // a completing rise wins over a coincident timeout
                if (rise && scnt == SETTLE_LAST) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else if (tmo_hit) begin
                    done_nx    = 1'b1;
                    timeout_nx = 1'b1;
                    state_nx   = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and registered outputs; reset re-runs the default-ratio load
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_HOLD;
            hcnt     <= 4'd0;
            scnt     <= 4'd0;
            tcnt     <= 8'd0;
            pending  <= DEF_N;
            div_n    <= DEF_N;
            div_rstn <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            timeout  <= 1'b0;
            fb_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            hcnt     <= hcnt_nx;
            scnt     <= scnt_nx;
            tcnt     <= tcnt_nx;
            pending  <= pending_nx;
            div_n    <= div_n_nx;
            div_rstn <= div_rstn_nx;
            done     <= done_nx;
            err      <= err_nx;
            timeout  <= timeout_nx;
            fb_q     <= clko_fb;
        end
    end

endmodule
